hilo_issue_queue: RTL and testbench

//  In-order issue queue for HI/LO-class instructions (mfhi/mflo/mthi/mtlo/mult/multu/div/divu), directly upstream of the HI/LO functional unit.

---
 rtl/hilo_issue_queue_pkg.sv | 19 +
 rtl/hilo_iq_entry.sv | 82 ++++++++
 rtl/hilo_issue_queue.sv | 144 ++++++++++++++
 tb/tb_hilo_issue_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_issue_queue_pkg.sv
// Shared definitions for the HI/LO issue queue: status-word layout and op classification.
// Latency: none (package only).
// Backpressure: n/a.
package hilo_issue_queue_pkg;

    // Status word width and op-code width carried alongside each queued op
    localparam int INST_STATE_WD = 16;
    localparam int OP_WD         = 12;

    // [`OP] field: {mfhi,mflo,mthi,mtlo,mult,multu,div,divu} at status[OP_MSB:OP_LSB]
    localparam int OP_LSB = 0;
    localparam int OP_MSB = OP_LSB + 7;

    // Returns {reads_hilo, writes_hilo} for an [`OP] field
    function automatic logic [1:0] hilo_class(input logic [7:0] op_field);
        return {op_field[7] | op_field[6], |op_field[5:0]};
    endfunction

endpackage

// File: rtl/hilo_iq_entry.sv
// Single issue-queue slot: holds op/status/rs operand and snoops writeback for its rs tag.
// Latency: wakeup lands one edge after the broadcast; with HILO_IQ_BYPASS_EN the broadcast is also forwarded combinationally.
// Backpressure: none; the parent only writes free slots and only releases the head slot.
module hilo_iq_entry
    import hilo_issue_queue_pkg::*;
#(
    parameter int TAG_WD = 6
)(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic                     wr_rdy,
    input  logic [TAG_WD-1:0]        wr_tag,
    input  logic [31:0]              wr_val,
    input  logic [OP_WD-1:0]         wr_op,
    input  logic [INST_STATE_WD-1:0] wr_status,
    input  logic                     rd_en,
    input  logic                     wb_valid,
    input  logic [TAG_WD-1:0]        wb_tag,
    input  logic [31:0]              wb_data,
    output logic                     valid,
    output logic                     rdy_eff,
    output logic [31:0]              val_eff,
    output logic [OP_WD-1:0]         op,
    output logic [INST_STATE_WD-1:0] status
);

    logic              rdy;
    logic [TAG_WD-1:0] tag;
    logic [31:0]       value;
    logic              hit;
    logic              wr_hit;

    assign hit    = valid & ~rdy & wb_valid & (wb_tag == tag);
    assign wr_hit = wb_valid & (wb_tag == wr_tag);

`ifdef HILO_IQ_BYPASS_EN
    assign rdy_eff = rdy | hit;
    assign val_eff = rdy ? value : wb_data;
`else
    assign rdy_eff = rdy;
    assign val_eff = value;
`endif

    // Slot state: allocate on write, release on issue, otherwise capture a matching writeback
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid  <= 1'b0;
            rdy    <= 1'b0;
            tag    <= '0;
            value  <= '0;
            op     <= '0;
            status <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            rdy   <= 1'b0;
        end else if (wr_en) begin
            valid  <= 1'b1;
            tag    <= wr_tag;
            op     <= wr_op;
            status <= wr_status;
            if (wr_rdy) begin
                rdy   <= 1'b1;
                value <= wr_val;
            end else if (wr_hit) begin
                rdy   <= 1'b1;
                value <= wb_data;
            end else begin
                rdy   <= 1'b0;
                value <= wr_val;
            end
        end else if (rd_en) begin
            valid <= 1'b0;
            rdy   <= 1'b0;
        end else if (hit) begin
            rdy   <= 1'b1;
            value <= wb_data;
        end
    end

endmodule

// File: rtl/hilo_issue_queue.sv
// In-order HI/LO issue queue: issues the head op when its rs is ready, the FU is idle and no HI/LO hazard exists.
// Latency: dispatch->issue >= 1 cycle; HILO_IQ_BYPASS_EN lets a head woken this cycle issue with the broadcast value.
// Backpressure: disp_ready drops at DEPTH entries (registered count, even while issuing); fu_busy holds issue.
module hilo_issue_queue
    import hilo_issue_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TAG_WD   = 6,
    parameter int PEND_MAX = 3
)(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [OP_WD-1:0]         disp_op,
    input  logic [INST_STATE_WD-1:0] disp_inst_status,
    input  logic                     disp_src1_rdy,
    input  logic [TAG_WD-1:0]        disp_src1_tag,
    input  logic [31:0]              disp_src1_val,
    input  logic                     wb_valid,
    input  logic [TAG_WD-1:0]        wb_tag,
    input  logic [31:0]              wb_data,
    input  logic [63:0]              hilo_rdata,
    input  logic                     hilo_commit,
    input  logic                     fu_busy,
    output logic                     issue_ready,
    output logic [OP_WD-1:0]         issue_op,
    output logic [INST_STATE_WD-1:0] issue_inst_status,
    output logic [31:0]              issue_rdata1,
    output logic [63:0]              issue_rdata2
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int PCW = $clog2(PEND_MAX + 1);

    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [PCW-1:0] pending;
    logic [PCW-1:0] pending_nxt;

    logic                     ent_valid  [DEPTH];
    logic                     ent_rdy    [DEPTH];
    logic [31:0]              ent_val    [DEPTH];
    logic [OP_WD-1:0]         ent_op     [DEPTH];
    logic [INST_STATE_WD-1:0] ent_status [DEPTH];

    logic       disp_acc;
    logic       issue;
    logic       hazard_ok;
    logic [1:0] head_class;
    logic       pend_inc;
    logic       pend_dec;

    assign disp_ready = (count != CW'(DEPTH));
    assign disp_acc   = disp_valid & disp_ready & ~flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            hilo_iq_entry #(.TAG_WD(TAG_WD)) u_ent (
                .clk       (clk),
                .resetn    (resetn),
                .clear     (flush),
                .wr_en     (disp_acc & (tail == PW'(gi))),
                .wr_rdy    (disp_src1_rdy),
                .wr_tag    (disp_src1_tag),
                .wr_val    (disp_src1_val),
                .wr_op     (disp_op),
                .wr_status (disp_inst_status),
                .rd_en     (issue & (head == PW'(gi))),
                .wb_valid  (wb_valid),
                .wb_tag    (wb_tag),
                .wb_data   (wb_data),
                .valid     (ent_valid[gi]),
                .rdy_eff   (ent_rdy[gi]),
                .val_eff   (ent_val[gi]),
                .op        (ent_op[gi]),
                .status    (ent_status[gi])
            );
        end
    endgenerate

    // Readers need every issued writer committed; writers are capped by PEND_MAX outstanding
    always_comb begin
        head_class = hilo_class(ent_status[head][OP_MSB:OP_LSB]);
        hazard_ok  = 1'b1;
        if (head_class[1])
            hazard_ok = (pending == '0);
        else if (head_class[0])
            hazard_ok = (pending < PCW'(PEND_MAX));
    end

    assign issue = (count != '0) & ent_valid[head] & ent_rdy[head] & ~fu_busy & ~flush & hazard_ok;

    assign issue_ready       = issue;
    assign issue_op          = issue ? ent_op[head]     : '0;
    assign issue_inst_status = issue ? ent_status[head] : '0;
    assign issue_rdata1      = issue ? ent_val[head]    : '0;
    assign issue_rdata2      = issue ? hilo_rdata       : '0;

    assign pend_inc = issue & head_class[0];
    assign pend_dec = hilo_commit & (pending != '0);

    // Next occupancy and outstanding-writer count; simultaneous +1/-1 cancel
    always_comb begin
        count_nxt = count;
        if (disp_acc && !issue)
            count_nxt = count + CW'(1);
        else if (!disp_acc && issue)
            count_nxt = count - CW'(1);
        pending_nxt = pending;
        if (pend_inc && !pend_dec)
            pending_nxt = pending + PCW'(1);
        else if (pend_dec && !pend_inc)
            pending_nxt = pending - PCW'(1);
    end

    // Queue pointers, occupancy and pending-writer counter; flush empties everything
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pending <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pending <= '0;
        end else begin
            if (disp_acc)
                tail <= tail + PW'(1);
            if (issue)
                head <= head + PW'(1);
            count   <= count_nxt;
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_hilo_issue_queue.sv
// Directed bench for hilo_issue_queue: scoreboard of expected issues, checked whenever issue_ready pulses.
// Latency: inputs driven at negedge, outputs sampled 2 time units before the next posedge.
// Backpressure: exercised via fu_busy, full queue, hazards and flush.
module tb_hilo_issue_queue;

    localparam logic [15:0] MFHI  = 16'h0080;
    localparam logic [15:0] MFLO  = 16'h0040;
    localparam logic [15:0] MTHI  = 16'h0020;
    localparam logic [15:0] MTLO  = 16'h0010;
    localparam logic [15:0] MULT  = 16'h0008;
    localparam logic [15:0] MULTU = 16'h0004;
    localparam logic [15:0] DIV   = 16'h0002;
    localparam logic [15:0] DIVU  = 16'h0001;

`ifdef HILO_IQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [11:0] disp_op;
    logic [15:0] disp_inst_status;
    logic        disp_src1_rdy;
    logic [5:0]  disp_src1_tag;
    logic [31:0] disp_src1_val;
    logic        wb_valid;
    logic [5:0]  wb_tag;
    logic [31:0] wb_data;
    logic [63:0] hilo_rdata;
    logic        hilo_commit;
    logic        fu_busy;
    logic        issue_ready;
    logic [11:0] issue_op;
    logic [15:0] issue_inst_status;
    logic [31:0] issue_rdata1;
    logic [63:0] issue_rdata2;

    typedef struct {
        logic [11:0] op;
        logic [15:0] st;
        logic [31:0] r1;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    hilo_issue_queue dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .disp_valid        (disp_valid),
        .disp_ready        (disp_ready),
        .disp_op           (disp_op),
        .disp_inst_status  (disp_inst_status),
        .disp_src1_rdy     (disp_src1_rdy),
        .disp_src1_tag     (disp_src1_tag),
        .disp_src1_val     (disp_src1_val),
        .wb_valid          (wb_valid),
        .wb_tag            (wb_tag),
        .wb_data           (wb_data),
        .hilo_rdata        (hilo_rdata),
        .hilo_commit       (hilo_commit),
        .fu_busy           (fu_busy),
        .issue_ready       (issue_ready),
        .issue_op          (issue_op),
        .issue_inst_status (issue_inst_status),
        .issue_rdata1      (issue_rdata1),
        .issue_rdata2      (issue_rdata2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        disp_valid  = 1'b0;
        wb_valid    = 1'b0;
        hilo_commit = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic disp(input logic [11:0] op, input logic [15:0] st, input logic rdy,
                        input logic [5:0] tag, input logic [31:0] val,
                        input logic [31:0] exp_r1, input bit push);
        disp_valid       = 1'b1;
        disp_op          = op;
        disp_inst_status = st;
        disp_src1_rdy    = rdy;
        disp_src1_tag    = tag;
        disp_src1_val    = val;
        if (push)
            sb.push_back('{op, st, exp_r1});
    endtask

    task automatic wb(input logic [5:0] tag, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_tag   = tag;
        wb_data  = data;
    endtask

    // Called at a negedge with inputs set; samples before the posedge, returns at the next negedge
    task automatic cycle(input logic exp_iss);
        exp_t e;
        #3;
        chk("issue_ready", issue_ready, exp_iss);
        if (issue_ready === 1'b1) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("issue_op", issue_op, e.op);
                chk("issue_status", issue_inst_status, e.st);
                chk("issue_rdata1", issue_rdata1, e.r1);
                chk("issue_rdata2", issue_rdata2, hilo_rdata);
            end
        end else begin
            chk("idle_status", issue_inst_status, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0; fu_busy = 1'b0; idle();
        disp_op = '0; disp_inst_status = '0; disp_src1_rdy = 1'b0;
        disp_src1_tag = '0; disp_src1_val = '0; wb_tag = '0; wb_data = '0;
        hilo_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        #2;
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_issue_status", issue_inst_status, 0);
        chk("rst_issue_op", issue_op, 0);
        chk("rst_rdata1", issue_rdata1, 0);
        chk("rst_rdata2", issue_rdata2, 0);
        chk("rst_disp_ready", disp_ready, 1);
        @(negedge clk);
        resetn = 1'b1;

        // 1: mthi issues next cycle; a following mfhi waits for its commit
        idle(); disp(12'h101, MTHI, 1, 0, 32'h1234, 32'h1234, 1); cycle(0);
        idle(); disp(12'h102, MFHI, 1, 0, 32'h0, 32'h0, 1); cycle(1);
        idle(); cycle(0);
        idle(); hilo_commit = 1'b1; cycle(0);
        idle(); cycle(1);

        // 2: operand woken by writeback tag 5 (wrong tag ignored)
        idle(); disp(12'h201, MULT, 0, 6'd5, 32'hDEAD, 32'd7, 1); cycle(0);
        idle(); wb(6'd6, 32'd99); cycle(0);
        idle(); wb(6'd5, 32'd7); cycle(BYP);
        idle(); cycle(!BYP);
        idle(); hilo_commit = 1'b1; cycle(0);
        // 2b: wakeup in the dispatch cycle itself
        idle(); disp(12'h202, MTLO, 0, 6'd9, 32'h0, 32'h55, 1); wb(6'd9, 32'h55); cycle(0);
        idle(); cycle(1);
        idle(); hilo_commit = 1'b1; cycle(0);

        // 3: mult then mfhi; mfhi holds until commit, rdata2 sampled at issue
        hilo_rdata = 64'h1111_2222_3333_4444;
        idle(); disp(12'h301, MULT, 1, 0, 32'd3, 32'd3, 1); cycle(0);
        idle(); disp(12'h302, MFHI, 1, 0, 32'd0, 32'd0, 1); cycle(1);
        idle(); cycle(0);
        idle(); hilo_commit = 1'b1; cycle(0);
        idle(); hilo_rdata = 64'h5555_6666_7777_8888; cycle(1);

        // 4: fill under fu_busy, full queue rejects (also while issuing), then in-order drain
        fu_busy = 1'b1;
        idle(); disp(12'h401, MFLO, 1, 0, 32'hA1, 32'hA1, 1); cycle(0);
        idle(); disp(12'h402, MFHI, 1, 0, 32'hA2, 32'hA2, 1); cycle(0);
        idle(); disp(12'h403, MFLO, 1, 0, 32'hA3, 32'hA3, 1); cycle(0);
        idle(); disp(12'h404, MFHI, 1, 0, 32'hA4, 32'hA4, 1); cycle(0);
        chk("full_disp_ready", disp_ready, 0);
        idle(); disp(12'h405, MFLO, 1, 0, 32'hA5, 32'hA5, 0); cycle(0);
        fu_busy = 1'b0;
        chk("full_issue_disp_ready", disp_ready, 0);
        idle(); disp(12'h406, MFLO, 1, 0, 32'hA6, 32'hA6, 0); cycle(1);
        idle(); cycle(1);
        idle(); cycle(1);
        idle(); cycle(1);
        idle(); cycle(0);

        // 5: writer cap at 3 pending; commit+issue together leaves the count unchanged
        idle(); disp(12'h501, MULT,  1, 0, 32'hB1, 32'hB1, 1); cycle(0);
        idle(); disp(12'h502, MULTU, 1, 0, 32'hB2, 32'hB2, 1); cycle(1);
        idle(); disp(12'h503, DIV,   1, 0, 32'hB3, 32'hB3, 1); cycle(1);
        idle(); disp(12'h504, DIVU,  1, 0, 32'hB4, 32'hB4, 1); cycle(1);
        idle(); cycle(0);
        idle(); hilo_commit = 1'b1; cycle(0);
        idle(); disp(12'h505, MTHI, 1, 0, 32'hB5, 32'hB5, 1); cycle(1);
        idle(); cycle(0);
        idle(); hilo_commit = 1'b1; cycle(0);
        idle(); hilo_commit = 1'b1; cycle(1);
        idle(); disp(12'h506, MTLO, 1, 0, 32'hB6, 32'hB6, 1); cycle(0);
        idle(); cycle(1);
        idle(); disp(12'h507, MULT, 1, 0, 32'hB7, 32'hB7, 0); cycle(0);
        idle(); cycle(0);

        // 6: flush with 3 entries and an issuable head; dispatch in the flush cycle is dropped
        fu_busy = 1'b1;
        idle(); disp(12'h601, MFLO, 1, 0, 32'hC1, 32'hC1, 0); cycle(0);
        idle(); disp(12'h602, MFLO, 1, 0, 32'hC2, 32'hC2, 0); cycle(0);
        idle(); hilo_commit = 1'b1; cycle(0);
        fu_busy = 1'b0;
        idle(); flush = 1'b1; disp(12'h6EE, MFLO, 1, 0, 32'hEE, 32'hEE, 0); cycle(0);
        chk("flush_disp_ready", disp_ready, 1);
        idle(); cycle(0);
        idle(); disp(12'h603, MFHI, 1, 0, 32'hC3, 32'hC3, 1); cycle(0);
        idle(); cycle(1);
        chk("sb_drained", sb.size(), 0);

        // Async reset with ready entries queued: outputs clear at once, nothing issues afterwards
        fu_busy = 1'b1;
        idle(); disp(12'h701, MTHI, 1, 0, 32'hD1, 32'hD1, 1); cycle(0);
        idle(); disp(12'h702, MTHI, 1, 0, 32'hD2, 32'hD2, 1); cycle(0);
        idle(); fu_busy = 1'b0; resetn = 1'b0;
        #1;
        chk("arst_issue_ready", issue_ready, 0);
        chk("arst_issue_status", issue_inst_status, 0);
        chk("arst_issue_op", issue_op, 0);
        chk("arst_rdata1", issue_rdata1, 0);
        chk("arst_rdata2", issue_rdata2, 0);
        chk("arst_disp_ready", disp_ready, 1);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        idle(); cycle(0);
        idle(); cycle(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
